// File: rtl/neuron_preact_mac_pkg.sv
// Shared Q8.24 constants, FSM state type and the final saturation helper for the
// neuron pre-activation MAC.
package neuron_preact_mac_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FRAC_W = 24;
    localparam int unsigned ACC_W  = 48;

    localparam logic [DATA_W-1:0] Q_ONE = 32'h0100_0000;
    localparam logic [DATA_W-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] Q_MIN = 32'h8000_0000;

    // Q_MAX / Q_MIN sign-extended to accumulator width for the clamp compares.
    localparam logic signed [ACC_W-1:0] ACC_Q_MAX = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
    localparam logic signed [ACC_W-1:0] ACC_Q_MIN = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StFin  = 2'd2,
        StOut  = 2'd3
    } state_e;

    // Clamp an accumulator value to Q8.24; result is {clipped, value}.
    function automatic logic [DATA_W:0] sat_to_q8_24(input logic signed [ACC_W-1:0] acc);
        logic [DATA_W:0] res;
        if (acc > ACC_Q_MAX) begin
            res = {1'b1, Q_MAX};
        end else if (acc < ACC_Q_MIN) begin
            res = {1'b1, Q_MIN};
        end else begin
            res = {1'b0, acc[DATA_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_preact_mac_q_mul_shift.sv
// Combinational signed Q8.24 multiply: full-width product, arithmetic shift right by
// FRAC_W (floor), sign-extended to the accumulator width.
module q_mul_shift #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 24,
    parameter int unsigned ACC_W  = 48
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  p_o
);

    localparam int unsigned ProdW = 2 * DATA_W;
    localparam int unsigned KeepW = ProdW - FRAC_W;

    logic [ProdW-1:0] a_ext;
    logic [ProdW-1:0] b_ext;
    logic [ProdW-1:0] prod;
    logic             unused_frac;

    // Low ProdW bits of the sign-extended product equal the signed product.
    always_comb begin
        a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
        b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
        prod  = a_ext * b_ext;
        // Dropping the low FRAC_W bits of a two's-complement value rounds toward -inf.
        p_o   = {{(ACC_W-KeepW){prod[ProdW-1]}}, prod[ProdW-1:FRAC_W]};
    end

    assign unused_frac = ^prod[FRAC_W-1:0];

endmodule

// File: rtl/neuron_preact_mac.sv
// One neuron pre-activation: z = sum(x_i * w_i) + bias in signed Q8.24, saturated.
// Operand pairs stream in under valid/ready; z leaves under valid/ready.
module neuron_preact_mac
    import neuron_preact_mac_pkg::*;
#(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned DATA_W   = neuron_preact_mac_pkg::DATA_W,
    parameter int unsigned FRAC_W   = neuron_preact_mac_pkg::FRAC_W,
    parameter int unsigned ACC_W    = neuron_preact_mac_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    output logic              z_valid,
    input  logic              z_ready,
    output logic [DATA_W-1:0] z_out,
    output logic              busy,
    output logic              sat_flag
);

    localparam int unsigned CntW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N_INPUTS - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] bias_q, bias_d;
    logic [DATA_W-1:0] z_q, z_d;
    logic              sat_q, sat_d;

    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  acc_plus_bias;

    q_mul_shift #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .a_i (x_in),
        .b_i (w_in),
        .p_o (prod)
    );

    // Next-state logic for the FSM, beat counter, accumulator and result registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        bias_d        = bias_q;
        z_d           = z_q;
        sat_d         = sat_q;
        acc_plus_bias = acc_q + {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (in_valid) begin
                    acc_d = acc_q + prod;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                acc_d          = acc_plus_bias;
                {sat_d, z_d}   = sat_to_q8_24(acc_plus_bias);
                state_d        = StOut;
            end
            StOut: begin
                // start is deliberately not looked at here; it must be re-raised in idle.
                if (z_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            bias_q  <= '0;
            z_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bias_q  <= bias_d;
            z_q     <= z_d;
            sat_q   <= sat_d;
        end
    end

    // Handshake and status outputs are pure decodes of the registered state.
    always_comb begin
        in_ready = (state_q == StAcc);
        z_valid  = (state_q == StOut);
        busy     = (state_q != StIdle);
        z_out    = z_q;
        sat_flag = sat_q;
    end

endmodule

// File: tb/tb_neuron_preact_mac.sv
// Directed self-checking bench for neuron_preact_mac (N_INPUTS = 4).
module tb_neuron_preact_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_in = '0;
    logic [31:0] w_in = '0;
    logic        z_valid;
    logic        z_ready = 1'b0;
    logic [31:0] z_out;
    logic        busy;
    logic        sat_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;

    logic [31:0] xv [4];
    logic [31:0] wv [4];
    int          gapv [4];

    neuron_preact_mac #(
        .N_INPUTS (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .w_in     (w_in),
        .z_valid  (z_valid),
        .z_ready  (z_ready),
        .z_out    (z_out),
        .busy     (busy),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && z_valid && z_ready) hs_count <= hs_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [31:0] x, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            xv[i]   = x;
            wv[i]   = w;
            gapv[i] = 0;
        end
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat (gapv[i]) step();
            x_in     = xv[i];
            w_in     = wv[i];
            in_valid = 1'b1;
            for (int g = 0; g < 20 && !in_ready; g++) step();
            check_eq("in_ready_before_beat", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_z_valid();
        for (int g = 0; g < 20 && !z_valid; g++) step();
        check_eq("z_valid_arrives", z_valid, 1);
    endtask

    // Full neuron: start, four beats, hold z_ready low for zhold cycles, one handshake.
    task automatic run_neuron(input string tag, input logic [31:0] b, input int zhold,
                              input logic [31:0] exp_z, input logic exp_sat);
        int hs0;
        z_ready = 1'b0;
        start   = 1'b1;
        bias    = b;
        step();
        start   = 1'b0;
        bias    = 32'hDEAD_BEEF;
        send_beats(4);
        wait_z_valid();
        check_eq({tag, "_z"}, z_out, exp_z);
        check_eq({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, exp_sat});
        for (int i = 0; i < zhold; i++) begin
            step();
            check_eq({tag, "_hold_valid"}, z_valid, 1);
            check_eq({tag, "_hold_z"}, z_out, exp_z);
        end
        hs0     = hs_count;
        z_ready = 1'b1;
        step();
        z_ready = 1'b0;
        check_eq({tag, "_one_handshake"}, hs_count - hs0, 1);
        check_eq({tag, "_valid_drop"}, z_valid, 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int marks [$];
        int hs0;

        // Reset state.
        rst_n = 1'b0;
        step();
        step();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_z_valid", z_valid, 0);
        check_eq("rst_z_out", z_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sat", sat_flag, 0);
        rst_n = 1'b1;
        step();

        // 4 x (1.0 * 0.5) = 2.0
        set_vec(32'h0100_0000, 32'h0080_0000);
        run_neuron("basic", 32'h0, 0, 32'h0200_0000, 1'b0);

        // 4 x (-1.0 * 0.25) + 0.5 = -0.5
        set_vec(32'hFF00_0000, 32'h0040_0000);
        run_neuron("sign_bias", 32'h0080_0000, 0, 32'hFF80_0000, 1'b0);

        // 127*127*4 overflows both ways.
        set_vec(32'h7F00_0000, 32'h7F00_0000);
        run_neuron("sat_pos", 32'h0, 0, 32'h7FFF_FFFF, 1'b1);
        set_vec(32'h8100_0000, 32'h7F00_0000);
        run_neuron("sat_neg", 32'h0, 0, 32'h8000_0000, 1'b1);

        // Smallest negative times 0.5 floors to -2^-24 each beat: -4 LSB total.
        set_vec(32'hFFFF_FFFF, 32'h0080_0000);
        run_neuron("floor", 32'h0, 0, 32'hFFFF_FFFC, 1'b0);

        // Input gaps and 5 cycles of backpressure.
        set_vec(32'h0100_0000, 32'h0080_0000);
        gapv[0] = 2; gapv[1] = 0; gapv[2] = 3; gapv[3] = 1;
        run_neuron("stall", 32'h0, 5, 32'h0200_0000, 1'b0);

        // start during ACC (with a different bias) must be ignored.
        set_vec(32'h0100_0000, 32'h0080_0000);
        z_ready = 1'b0;
        start = 1'b1; bias = 32'h0; step();
        start = 1'b0;
        send_beats(2);
        start = 1'b1; bias = 32'h0100_0000; step();
        start = 1'b0; bias = 32'h0;
        check_eq("acc_start_busy", busy, 1);
        x_in = xv[2]; w_in = wv[2]; in_valid = 1'b1; step();
        x_in = xv[3]; w_in = wv[3]; step();
        in_valid = 1'b0;
        wait_z_valid();
        check_eq("acc_start_ignored_z", z_out, 32'h0200_0000);
        // start during OUT, including the handshake cycle, must not begin a neuron.
        start = 1'b1; step();
        check_eq("out_start_hold", z_valid, 1);
        z_ready = 1'b1; step();
        start = 1'b0; z_ready = 1'b0;
        check_eq("out_start_ignored", busy, 0);
        step();
        check_eq("out_start_still_idle", busy, 0);

        // Reset after two beats aborts the neuron.
        start = 1'b1; bias = 32'h0080_0000; step();
        start = 1'b0;
        send_beats(2);
        rst_n = 1'b0; step();
        check_eq("abort_in_ready", in_ready, 0);
        check_eq("abort_z_valid", z_valid, 0);
        check_eq("abort_z_out", z_out, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_sat", sat_flag, 0);
        rst_n = 1'b1; step();
        run_neuron("after_abort", 32'h0, 0, 32'h0200_0000, 1'b0);

        // Latency: last beat accepted in cycle k -> z_valid in cycle k+2.
        z_ready = 1'b1;
        start = 1'b1; bias = 32'h0; step();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        check_eq("lat_fin_no_valid", z_valid, 0);
        step();
        check_eq("lat_valid_k2", z_valid, 1);
        check_eq("lat_z", z_out, 32'h0200_0000);
        step();
        check_eq("lat_done", z_valid, 0);

        // Back-to-back neurons with everything held high: one z every 7 cycles.
        hs0 = hs_count;
        start = 1'b1; in_valid = 1'b1; z_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (z_valid) begin
                marks.push_back(c);
                check_eq("b2b_z", z_out, 32'h0200_0000);
            end
        end
        check_eq("b2b_count_ge3", marks.size() >= 3, 1);
        for (int i = 1; i < marks.size(); i++) begin
            check_eq("b2b_period", marks[i] - marks[i-1], 7);
        end
        for (int g = 0; g < 20 && !z_valid; g++) step();
        start = 1'b0;
        in_valid = 1'b0;
        step();
        check_eq("b2b_handshakes", hs_count - hs0, marks.size() + 1);
        check_eq("b2b_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
